// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a 5-stage in-order core. It detects
//   load-use hazards between the instructions in EXE and ID. It holds the
//   front of the pipe while a multi-cycle (mul/div) op occupies EXE. It also
//   squashes the wrong-path instructions when a branch resolves taken in EXE.
//
//   Handshake/timing: there is no valid/ready pair. Every control output
//   other than stall_cycles is a pure combinational function of the current
//   state, the down-counter and the inputs. The pipeline registers act on
//   these outputs at the next rising edge.
//
// Parameters
//   LOAD_STALL  stall cycles per load-use hazard (1..7)
//   MC_CYCLES   EXE occupancy of a multi-cycle op in cycles (2..32)
//   PERF_W      width of the stall performance counter
//
// Ports
//   clk, rst_n                        clock, synchronous active-low reset
//   IF_ID_read_reg1/2, IF_ID_use_rs1/2  source regs of ID instr and their use
//   ID_EXE_written_reg, ID_EXE_data_to_reg, ID_EXE_mc_op  EXE instr info
//   branch_taken                      redirect resolved in EXE this cycle
//   PC_dstall, IF_ID_dstall           hold PC / IF_ID
//   ID_EXE_dstall, ID_EXE_bubble      hold ID_EXE / load NOP into ID_EXE
//   IF_ID_flush, ID_EXE_flush         squash IF_ID / ID_EXE
//   busy                              FSM not idle
//   stall_cycles                      saturating count of PC stall cycles
//   dbg_state                         current FSM state (debug observation)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int MC_CYCLES  = 4,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        IF_ID_read_reg1,
  input  logic [4:0]        IF_ID_read_reg2,
  input  logic              IF_ID_use_rs1,
  input  logic              IF_ID_use_rs2,
  input  logic [4:0]        ID_EXE_written_reg,
  input  logic [1:0]        ID_EXE_data_to_reg,
  input  logic              ID_EXE_mc_op,
  input  logic              branch_taken,
  output logic              PC_dstall,
  output logic              IF_ID_dstall,
  output logic              ID_EXE_dstall,
  output logic              ID_EXE_bubble,
  output logic              IF_ID_flush,
  output logic              ID_EXE_flush,
  output logic              busy,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_MC_WAIT   = 2'd2
  } state_t;

  // Counter preloads: the cycle spent in IDLE detecting the event is the
  // first stall cycle, so the wait states cover the remainder.
  localparam logic [5:0] LD_INIT = 6'(LOAD_STALL - 1);
  localparam logic [5:0] MC_INIT = 6'(MC_CYCLES - 2);

  state_t            r_state;
  state_t            w_next_state;
  logic [5:0]        r_cnt;
  logic [5:0]        w_next_cnt;
  logic [PERF_W-1:0] r_stall_cycles;

  logic w_load_hz;
  logic w_front_stall;
  logic w_exe_hold;
  logic w_bubble;
  logic w_flush;

  assign w_load_hz = (ID_EXE_data_to_reg == 2'b01) &&
                     (ID_EXE_written_reg != 5'd0) &&
                     ((IF_ID_use_rs1 && (ID_EXE_written_reg == IF_ID_read_reg1)) ||
                      (IF_ID_use_rs2 && (ID_EXE_written_reg == IF_ID_read_reg2)));

  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_front_stall = 1'b0;
    w_exe_hold    = 1'b0;
    w_bubble      = 1'b0;
    w_flush       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // mc_op beats branch_taken beats load_hz; losers are dropped.
        if (ID_EXE_mc_op) begin
          w_front_stall = 1'b1;
          w_exe_hold    = 1'b1;
          if (MC_CYCLES > 2) begin
            w_next_state = S_MC_WAIT;
            w_next_cnt   = MC_INIT;
          end
        end else if (branch_taken) begin
          w_flush = 1'b1;
        end else if (w_load_hz) begin
          w_front_stall = 1'b1;
          w_bubble      = 1'b1;
          if (LOAD_STALL > 1) begin
            w_next_state = S_LOAD_WAIT;
            w_next_cnt   = LD_INIT;
          end
        end
      end
      S_LOAD_WAIT: begin
        w_front_stall = 1'b1;
        w_bubble      = 1'b1;
        w_next_cnt    = r_cnt - 6'd1;
        if (r_cnt == 6'd1) w_next_state = S_IDLE;
      end
      S_MC_WAIT: begin
        w_front_stall = 1'b1;
        w_exe_hold    = 1'b1;
        w_next_cnt    = r_cnt - 6'd1;
        if (r_cnt == 6'd1) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = 6'd0;
      end
    endcase
  end

  // While reset is held, every control output is forced low so the
  // pipeline never sees a stale stall or flush from an aborted wait.
  assign PC_dstall     = rst_n & w_front_stall;
  assign IF_ID_dstall  = rst_n & w_front_stall;
  assign ID_EXE_dstall = rst_n & w_exe_hold;
  assign ID_EXE_bubble = rst_n & w_bubble;
  assign IF_ID_flush   = rst_n & w_flush;
  assign ID_EXE_flush  = rst_n & w_flush;
  assign busy          = rst_n & (r_state != S_IDLE);
  assign stall_cycles  = r_stall_cycles;
  assign dbg_state     = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 6'd0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (PC_dstall && (r_stall_cycles != {PERF_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl with LOAD_STALL=2 and MC_CYCLES=4. A second
//   instance with PERF_W=4 shares the same stimulus so that counter
//   saturation can be observed. Each driven cycle pushes its hand-computed
//   expected outputs into exp_q. A monitor pops one entry on every falling
//   edge and compares it with both instances.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  // Expected word: {stall_cycles(32), stall_cycles_4(4), outs(7)}
  // outs = {PC_dstall, IF_ID_dstall, ID_EXE_dstall, ID_EXE_bubble,
  //         IF_ID_flush, ID_EXE_flush, busy}
  localparam int W = 43;

  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_LD0  = 7'b1101000;
  localparam logic [6:0] E_LD1  = 7'b1101001;
  localparam logic [6:0] E_MC0  = 7'b1110000;
  localparam logic [6:0] E_MC1  = 7'b1110001;
  localparam logic [6:0] E_BR   = 7'b0000110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0] rs1, rs2, rd;
  logic       use1, use2, mc_op, br;
  logic [1:0] dtr;

  logic        pc_st, ifid_st, idexe_st, bubble, ifid_fl, idexe_fl, busy;
  logic [31:0] stall_cycles;
  logic [1:0]  dbg_state;
  logic        pc_st4, ifid_st4, idexe_st4, bubble4, ifid_fl4, idexe_fl4, busy4;
  logic [3:0]  stall_cycles4;
  logic [1:0]  dbg_state4;

  hazard_ctrl #(.LOAD_STALL(2), .MC_CYCLES(4), .PERF_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_read_reg1(rs1), .IF_ID_read_reg2(rs2),
    .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
    .ID_EXE_written_reg(rd), .ID_EXE_data_to_reg(dtr),
    .ID_EXE_mc_op(mc_op), .branch_taken(br),
    .PC_dstall(pc_st), .IF_ID_dstall(ifid_st),
    .ID_EXE_dstall(idexe_st), .ID_EXE_bubble(bubble),
    .IF_ID_flush(ifid_fl), .ID_EXE_flush(idexe_fl),
    .busy(busy), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  hazard_ctrl #(.LOAD_STALL(2), .MC_CYCLES(4), .PERF_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_read_reg1(rs1), .IF_ID_read_reg2(rs2),
    .IF_ID_use_rs1(use1), .IF_ID_use_rs2(use2),
    .ID_EXE_written_reg(rd), .ID_EXE_data_to_reg(dtr),
    .ID_EXE_mc_op(mc_op), .branch_taken(br),
    .PC_dstall(pc_st4), .IF_ID_dstall(ifid_st4),
    .ID_EXE_dstall(idexe_st4), .ID_EXE_bubble(bubble4),
    .IF_ID_flush(ifid_fl4), .ID_EXE_flush(idexe_fl4),
    .busy(busy4), .stall_cycles(stall_cycles4), .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_sum = 0;   // stall cycles counted so far (edges already taken)
  int step_no = 0;

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                      input logic a_u1, input logic a_u2, input logic [4:0] a_rd,
                      input logic [1:0] a_dtr, input logic a_mc, input logic a_br,
                      input logic [6:0] exp_outs);
    logic [3:0] sat4;
    @(posedge clk);
    #1;
    rst_n = r; rs1 = a_rs1; rs2 = a_rs2; use1 = a_u1; use2 = a_u2;
    rd = a_rd; dtr = a_dtr; mc_op = a_mc; br = a_br;
    sat4 = (exp_sum > 15) ? 4'hF : 4'(exp_sum);
    exp_q.push_back({32'(exp_sum), sat4, exp_outs});
    // Counter value seen after the coming edge.
    if (!r) exp_sum = 0;
    else if (exp_outs[6]) exp_sum = exp_sum + 1;
  endtask

  task automatic idle_step(input logic [6:0] exp_outs);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0, exp_outs);
  endtask

  task automatic mc_step(input logic [6:0] exp_outs);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b1, 1'b0, exp_outs);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      logic [6:0]   a4;
      e  = exp_q.pop_front();
      a  = {stall_cycles, stall_cycles4, pc_st, ifid_st, idexe_st, bubble, ifid_fl, idexe_fl, busy};
      a4 = {pc_st4, ifid_st4, idexe_st4, bubble4, ifid_fl4, idexe_fl4, busy4};
      checks = checks + 1;
      step_no = step_no + 1;
      if (a !== e || a4 !== e[6:0]) begin
        errors = errors + 1;
        $display("FAIL step%0d outs: got cnt=%0d cnt4=%0d o=%b o4=%b, need cnt=%0d cnt4=%0d o=%b",
                 step_no, a[42:11], a[10:7], a[6:0], a4, e[42:11], e[10:7], e[6:0]);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, need completion");
    errors = errors + 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; rs1 = '0; rs2 = '0; use1 = 0; use2 = 0;
    rd = '0; dtr = '0; mc_op = 0; br = 0;
    repeat (2) @(posedge clk);

    // reset state
    idle_step(E_NONE);
    // load-use via rs1: two stall cycles, busy in the second
    step(1, 5'd5, 5'd0, 1, 0, 5'd5, 2'b01, 0, 0, E_LD0);
    step(1, 5'd5, 5'd0, 1, 0, 5'd5, 2'b01, 0, 0, E_LD1);
    idle_step(E_NONE);
    // x0 destination and unused rs2 never stall
    step(1, 5'd0, 5'd0, 1, 0, 5'd0, 2'b01, 0, 0, E_NONE);
    step(1, 5'd7, 5'd7, 0, 0, 5'd7, 2'b01, 0, 0, E_NONE);
    // matching register but not a load
    step(1, 5'd5, 5'd0, 1, 0, 5'd5, 2'b00, 0, 0, E_NONE);
    // load-use via rs2; branch during LOAD_WAIT is ignored
    step(1, 5'd0, 5'd9, 0, 1, 5'd9, 2'b01, 0, 0, E_LD0);
    step(1, 5'd0, 5'd9, 0, 1, 5'd9, 2'b01, 0, 1, E_LD1);
    idle_step(E_NONE);
    // branch outranks load hazard
    step(1, 5'd3, 5'd0, 1, 0, 5'd3, 2'b01, 0, 1, E_BR);
    // mc_op outranks branch and load hazard
    step(1, 5'd3, 5'd0, 1, 0, 5'd3, 2'b01, 1, 1, E_MC0);
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 0, 1, E_MC1);
    idle_step(E_MC1);
    // back-to-back mc ops; mc_op inside MC_WAIT ignored
    mc_step(E_MC0);
    mc_step(E_MC1);
    mc_step(E_MC1);
    mc_step(E_MC0);
    idle_step(E_MC1);
    // reset in MC_WAIT with cnt==1: outputs forced low, then idle and cleared
    step(0, 5'd0, 5'd0, 0, 0, 5'd0, 2'b00, 1, 1, E_NONE);
    idle_step(E_NONE);
    // 21 stall cycles: 4-bit counter saturates at 15
    for (int i = 0; i < 7; i++) begin
      mc_step(E_MC0);
      idle_step(E_MC1);
      idle_step(E_MC1);
    end
    idle_step(E_NONE);
    idle_step(E_NONE);

    // drain: bounded wait for the monitor to consume everything
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1, meaning stall cycles per load-use hazard; legal 1..7.
REQ-002 Parameter MC_CYCLES, default 4, meaning EXE occupancy of a multi-cycle (mul/div) op in cycles; legal 2..32.
REQ-003 Parameter PERF_W, default 32, meaning width of the stall performance counter.
REQ-004 Port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  synchronous, active-low reset.
REQ-006 Ports IF_ID_read_reg1, IF_ID_read_reg2  input  5  source register numbers of the instruction in ID.
REQ-007 Ports IF_ID_use_rs1, IF_ID_use_rs2  input  1  source operand actually read by the ID instruction.
REQ-008 Port ID_EXE_written_reg  input  5  destination register of the instruction in EXE.
REQ-009 Port ID_EXE_data_to_reg  input  2  writeback select of the EXE instruction; 2'b01 = load.
REQ-010 Port ID_EXE_mc_op  input  1  EXE instruction is a multi-cycle op.
REQ-011 Port branch_taken  input  1  control redirect resolved in EXE this cycle.
REQ-012 Ports PC_dstall, IF_ID_dstall  output  1  hold PC / IF_ID register.
REQ-013 Port ID_EXE_dstall  output  1  hold ID_EXE register (instruction stays in EXE).
REQ-014 Port ID_EXE_bubble  output  1  load NOP into ID_EXE at next edge.
REQ-015 Ports IF_ID_flush, ID_EXE_flush  output  1  squash IF_ID / ID_EXE contents at next edge.
REQ-016 Ports busy  output  1  FSM not in IDLE; stall_cycles  output  PERF_W  count of cycles with PC_dstall=1.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_WAIT, MC_WAIT with a 6-bit down-counter cnt.
REQ-018 load_hz SHALL be: ID_EXE_data_to_reg==2'b01, ID_EXE_written_reg!=0, and (use_rs1 & rd==rs1 or use_rs2 & rd==rs2).
REQ-019 IDLE priority SHALL be ID_EXE_mc_op > branch_taken > load_hz; lower-priority events in the same cycle are ignored.
REQ-020 IDLE, mc_op=1: PC_dstall=IF_ID_dstall=ID_EXE_dstall=1 combinationally; if MC_CYCLES>2 go MC_WAIT with cnt=MC_CYCLES-2, else stay IDLE.
REQ-021 MC_WAIT: same three stalls asserted; cnt decrements each edge; at cnt==1 next state IDLE; total stall = MC_CYCLES-1 consecutive cycles.
REQ-022 IDLE, branch_taken=1 (no mc_op): IF_ID_flush=ID_EXE_flush=1, no stall, remain IDLE.
REQ-023 IDLE, load_hz=1: PC_dstall=IF_ID_dstall=ID_EXE_bubble=1; if LOAD_STALL>1 go LOAD_WAIT with cnt=LOAD_STALL-1, else stay IDLE.
REQ-024 LOAD_WAIT: PC_dstall=IF_ID_dstall=ID_EXE_bubble=1; cnt decrements; at cnt==1 next state IDLE; total stall = LOAD_STALL cycles.
REQ-025 branch_taken, mc_op and load_hz SHALL be ignored in LOAD_WAIT and MC_WAIT.
REQ-026 ID_EXE_dstall and ID_EXE_bubble SHALL never be 1 in the same cycle; flushes never coincide with any stall.
REQ-027 busy SHALL equal (state!=IDLE).
REQ-028 stall_cycles SHALL increment by 1 at each edge where PC_dstall=1, saturating at all-ones (no wrap).
REQ-029 All outputs other than stall_cycles SHALL be combinational from state, cnt and inputs; no output latency beyond that.

Reset
REQ-030 rst_n=0 at an edge SHALL set state=IDLE, cnt=0, stall_cycles=0, aborting any LOAD_WAIT/MC_WAIT.
REQ-031 While rst_n=0 all stall, bubble and flush outputs and busy SHALL be forced 0.

Verification (LOAD_STALL=2, MC_CYCLES=4 unless noted)
REQ-032 EXE rd=5 data_to_reg=01, ID rs1=5 use_rs1=1 -> PC/IF_ID stall + bubble for exactly 2 cycles, busy=1 in second, stall_cycles=2.
REQ-033 EXE rd=0 load, ID rs1=0; and EXE rd=7 load, ID rs2=7 use_rs2=0 -> no stall either case.
REQ-034 mc_op=1 one cycle in IDLE -> PC/IF_ID/ID_EXE_dstall for 3 cycles, bubble=0; back-to-back mc op retriggers 3 more.
REQ-035 branch_taken=1 with load_hz=1 in IDLE -> both flushes=1, no stall; branch_taken=1 during LOAD_WAIT -> ignored.
REQ-036 rst_n=0 in MC_WAIT with cnt=1 -> next cycle IDLE, all outputs 0, stall_cycles=0.
REQ-037 PERF_W=4, 20 stall cycles -> stall_cycles holds 4'hF.
